// File: rtl/seg7_capture_decode_if.sv
// Bundles the seven active-low segment lines and the decoded result of seg7_capture_decode.
// The display side drives the segments, and the decoder (slave) returns BCD, valid, blank and err.
interface seg7_capture_decode_if;
    logic       s0;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       s4;
    logic       s5;
    logic       s6;
    logic [2:0] BCD;
    logic       valid;
    logic       blank;
    logic       err;

    modport master (
        output s0, s1, s2, s3, s4, s5, s6,
        input  BCD, valid, blank, err
    );

    modport slave (
        input  s0, s1, s2, s3, s4, s5, s6,
        output BCD, valid, blank, err
    );
endinterface

// File: rtl/seg7_capture_decode.sv
// Recovers the 3-bit digit from smallCALC's active-low 7-segment lines once the
// synchronised pattern has held for STABLE_CYCLES clocks, and flags blank and illegal patterns.
module seg7_capture_decode #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CW            = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_capture_decode_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_SETTLE,
        ST_LOCKED,
        ST_BAD
    } state_t;

    typedef enum logic [1:0] {
        K_DIGIT,
        K_BLANK,
        K_ILLEGAL
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] digit;
    } decode_t;

    localparam logic [CW-1:0] LP_STABLE = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] LP_LAST   = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0]    LP_OFF    = 7'h7F;

    function automatic decode_t f_decode(input logic [6:0] seg);
        decode_t d;
        d.kind  = K_DIGIT;
        d.digit = 3'd0;
        unique case (seg)
            7'b0001000: d.digit = 3'd0;
            7'b1101101: d.digit = 3'd1;
            7'b0100010: d.digit = 3'd2;
            7'b0100100: d.digit = 3'd3;
            7'b1000101: d.digit = 3'd4;
            7'b0010100: d.digit = 3'd5;
            7'b0010000: d.digit = 3'd6;
            7'b0101101: d.digit = 3'd7;
            7'b1111111: d.kind  = K_BLANK;
            default:    d.kind  = K_ILLEGAL;
        endcase
        return d;
    endfunction

    logic [6:0]    w_seg_in;
    logic [6:0]    r_sync1;
    logic [6:0]    r_seg_s;
    logic [CW-1:0] r_cnt;
    logic          w_chg;
    logic          w_accept;
    decode_t       w_dec;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_bcd;
    logic [2:0]    w_bcd_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          r_blank;
    logic          w_blank_nxt;
    logic          r_err;
    logic          w_err_nxt;

    assign w_seg_in = {bus.s6, bus.s5, bus.s4, bus.s3, bus.s2, bus.s1, bus.s0};

    // Two-flop synchroniser; the lines may be asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= LP_OFF;
            r_seg_s <= LP_OFF;
        end else begin
            r_sync1 <= w_seg_in;
            r_seg_s <= r_sync1;
        end
    end

    // The change is seen on the same edge that seg_s takes its new value, so the
    // count restarts there and acceptance lands STABLE_CYCLES edges later.
    assign w_chg    = (r_sync1 != r_seg_s);
    assign w_accept = !w_chg && (r_cnt == LP_LAST);
    assign w_dec    = f_decode(r_seg_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_chg) begin
            r_cnt <= '0;
        end else if (r_cnt != LP_STABLE) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_bcd   <= 3'd0;
            r_valid <= 1'b0;
            r_blank <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcd   <= w_bcd_nxt;
            r_valid <= w_valid_nxt;
            r_blank <= w_blank_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Only SETTLE can accept; the saturated counter keeps it to one acceptance per run.
    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = r_bcd;
        w_valid_nxt = 1'b0;
        w_blank_nxt = r_blank;
        w_err_nxt   = r_err;
        if (w_chg) begin
            w_state_nxt = ST_SETTLE;
        end else if ((r_state == ST_SETTLE) && w_accept) begin
            unique case (w_dec.kind)
                K_DIGIT: begin
                    w_state_nxt = ST_LOCKED;
                    w_bcd_nxt   = w_dec.digit;
                    w_valid_nxt = 1'b1;
                    w_blank_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                end
                K_BLANK: begin
                    w_state_nxt = ST_BLANK;
                    w_blank_nxt = 1'b1;
                    w_err_nxt   = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_BAD;
                    w_blank_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                end
            endcase
        end
    end

    assign bus.BCD   = r_bcd;
    assign bus.valid = r_valid;
    assign bus.blank = r_blank;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_seg7_capture_decode.sv
// Bench for seg7_capture_decode: default and STABLE_CYCLES=1 instances share one stimulus
// stream, and each is compared every cycle against a run-length reference model.
module tb_seg7_capture_decode;

    logic clk;
    logic rst_n;

    seg7_capture_decode_if if0 ();
    seg7_capture_decode_if if1 ();

    seg7_capture_decode #(.STABLE_CYCLES(4), .CW(8)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    seg7_capture_decode #(.STABLE_CYCLES(1), .CW(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] DIG [8] = '{7'b0001000, 7'b1101101, 7'b0100010, 7'b0100100,
                            7'b1000101, 7'b0010100, 7'b0010000, 7'b0101101};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, index 0 = default instance, 1 = STABLE_CYCLES=1.
    int         m_s     [2] = '{4, 1};
    logic [6:0] m_prev  [2];
    int         m_run   [2];
    logic       m_pend  [2];
    logic [6:0] m_pendv [2];
    logic [2:0] m_bcd   [2];
    logic       m_valid [2];
    logic       m_blank [2];
    logic       m_err   [2];

    logic [6:0] cur_seg;
    int         vcnt0;
    int         vcnt1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        cur_seg = v;
        if0.s0 = v[0]; if0.s1 = v[1]; if0.s2 = v[2]; if0.s3 = v[3];
        if0.s4 = v[4]; if0.s5 = v[5]; if0.s6 = v[6];
        if1.s0 = v[0]; if1.s1 = v[1]; if1.s2 = v[2]; if1.s3 = v[3];
        if1.s4 = v[4]; if1.s5 = v[5]; if1.s6 = v[6];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_prev[i]  = 7'h7F;
            m_run[i]   = 1000;
            m_pend[i]  = 1'b0;
            m_pendv[i] = 7'h7F;
            m_bcd[i]   = 3'd0;
            m_valid[i] = 1'b0;
            m_blank[i] = 1'b1;
            m_err[i]   = 1'b0;
        end
    endtask

    // One clock edge of the model: a pattern seen on S+1 consecutive samples is
    // reported one edge later; anything shorter is ignored.
    task automatic model_edge(input logic [6:0] x);
        int d;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            if (m_pend[i]) begin
                d = -1;
                for (int k = 0; k < 8; k++) if (DIG[k] == m_pendv[i]) d = k;
                if (d >= 0) begin
                    m_bcd[i]   = 3'(d);
                    m_valid[i] = 1'b1;
                    m_blank[i] = 1'b0;
                    m_err[i]   = 1'b0;
                end else if (m_pendv[i] == 7'h7F) begin
                    m_blank[i] = 1'b1;
                    m_err[i]   = 1'b0;
                end else begin
                    m_blank[i] = 1'b0;
                    m_err[i]   = 1'b1;
                end
                m_pend[i] = 1'b0;
            end
            if (x == m_prev[i]) m_run[i] = (m_run[i] >= 1000) ? 1000 : m_run[i] + 1;
            else                m_run[i] = 1;
            m_prev[i] = x;
            if (m_run[i] == m_s[i] + 1) begin
                m_pend[i]  = 1'b1;
                m_pendv[i] = x;
            end
        end
    endtask

    task automatic compare_all();
        chk("bcd0",   8'(if0.BCD),   8'(m_bcd[0]));
        chk("valid0", 8'(if0.valid), 8'(m_valid[0]));
        chk("blank0", 8'(if0.blank), 8'(m_blank[0]));
        chk("err0",   8'(if0.err),   8'(m_err[0]));
        chk("bcd1",   8'(if1.BCD),   8'(m_bcd[1]));
        chk("valid1", 8'(if1.valid), 8'(m_valid[1]));
        chk("blank1", 8'(if1.blank), 8'(m_blank[1]));
        chk("err1",   8'(if1.err),   8'(m_err[1]));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(cur_seg);
        @(negedge clk);
        compare_all();
        if (if0.valid) vcnt0++;
        if (if1.valid) vcnt1++;
    endtask

    task automatic hold(input logic [6:0] v, input int n);
        drive(v);
        for (int c = 0; c < n; c++) step();
    endtask

    // Reset lands mid-cycle; outputs must clear before any clock edge.
    task automatic mid_reset(input logic [6:0] v_during);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_bcd0",   8'(if0.BCD),   8'h0);
        chk("rst_valid0", 8'(if0.valid), 8'h0);
        chk("rst_blank0", 8'(if0.blank), 8'h1);
        chk("rst_err0",   8'(if0.err),   8'h0);
        chk("rst_bcd1",   8'(if1.BCD),   8'h0);
        chk("rst_blank1", 8'(if1.blank), 8'h1);
        model_reset();
        hold(v_during, 2);
        rst_n = 1'b1;
    endtask

    logic [6:0] pat;
    int         r;

    initial begin
        rst_n = 1'b0;
        drive(7'h7F);
        model_reset();
        vcnt0 = 0;
        vcnt1 = 0;
        hold(7'h7F, 3);
        rst_n = 1'b1;

        // Idle blank after reset must stay quiet
        hold(7'h7F, 8);
        chk("idle_valids", 8'(vcnt0 + vcnt1), 8'd0);

        // All legal digits, 10 cycles each
        vcnt0 = 0;
        vcnt1 = 0;
        for (int d = 0; d < 8; d++) begin
            hold(DIG[d], 10);
            chk("seq_bcd0", 8'(if0.BCD), 8'(d));
        end
        chk("seq_pulses0", 8'(vcnt0), 8'd8);
        chk("seq_pulses1", 8'(vcnt1), 8'd8);

        // Glitch: 3 stable, 6 for three cycles, back to 3
        hold(DIG[3], 10);
        vcnt0 = 0;
        hold(DIG[6], 3);
        chk("glitch_none0", 8'(vcnt0), 8'd0);
        hold(DIG[3], 10);
        chk("glitch_ret0", 8'(vcnt0), 8'd1);
        chk("glitch_bcd0", 8'(if0.BCD), 8'd3);

        // Illegal then digit 2
        vcnt0 = 0;
        hold(7'b0000000, 10);
        chk("ill_err0",   8'(if0.err),   8'd1);
        chk("ill_bcd0",   8'(if0.BCD),   8'd3);
        chk("ill_valid0", 8'(vcnt0),     8'd0);
        hold(DIG[2], 10);
        chk("ill_clr0",   8'(if0.err),   8'd0);
        chk("ill_bcd2",   8'(if0.BCD),   8'd2);

        // Blank from digit 5
        hold(DIG[5], 10);
        vcnt0 = 0;
        hold(7'h7F, 10);
        chk("blk_blank0", 8'(if0.blank), 8'd1);
        chk("blk_bcd0",   8'(if0.BCD),   8'd5);
        chk("blk_valid0", 8'(vcnt0),     8'd0);

        // Reset mid-SETTLE, then release with blank inputs
        hold(DIG[4], 3);
        mid_reset(DIG[4]);
        hold(7'h7F, 1);
        drive(7'h7F);
        mid_reset(7'h7F);
        hold(7'h7F, 8);
        chk("rel_blank0", 8'(if0.blank), 8'd1);

        // Randomised segments of mixed patterns and lengths
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       pat = DIG[$urandom_range(0, 7)];
            else if (r < 8)  pat = 7'h7F;
            else             pat = 7'($urandom);
            if ($urandom_range(0, 39) == 0) mid_reset(pat);
            hold(pat, $urandom_range(1, 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_capture_decode.md
# seg7_capture_decode

Reads the active-low 7-segment drive lines `s0`..`s6` of the 3-bit digit display in smallCALC and recovers the 3-bit digit value. It does this only after the pattern has held stable for a programmable number of clock cycles. The block sits on the display side of the calculator, for self-check and loop-back of the BCD-to-segment path. It reports a one-cycle `valid` strobe per newly settled digit, and flags blank and unrecognised patterns.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical synchronised samples required before a pattern is accepted. Legal range 1..255.
- `CW`, default 8: width of the stability counter. Must satisfy 2^CW > STABLE_CYCLES.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `s0`..`s6` input 1 each: segment lines, active low (0 = lit). May be asynchronous to `clk`.
- `BCD` output [2:0]: last accepted digit value.
- `valid` output 1: one-cycle pulse when a new legal digit is accepted.
- `blank` output 1: level, high while the last accepted pattern is all-off.
- `err` output 1: level, high while the last accepted pattern is neither a legal digit nor blank.

## Operation
- **Input synchronisation:** the segment vector `seg = {s6,s5,s4,s3,s2,s1,s0}` passes through a 2-flop synchroniser, giving `seg_s`.
- **Legal digit patterns** (`seg` as {s6..s0}):
  - 0 = 0001000
  - 1 = 1101101
  - 2 = 0100010
  - 3 = 0100100
  - 4 = 1000101
  - 5 = 0010100
  - 6 = 0010000
  - 7 = 0101101
- **Blank pattern:** 1111111. Any other pattern is illegal.
- **Stability counter `cnt`:**
  - Reset to 0 on every edge where `seg_s` differs from its previous-cycle value.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
- **Acceptance:** a pattern is accepted on the edge where `cnt` reaches `STABLE_CYCLES`.
  - Acceptance happens once per stable run.
  - Acceptance repeats only after `seg_s` changes and re-settles.
- **State machine** `{BLANK, SETTLE, LOCKED, BAD}`, reset state BLANK:
  - Any state goes to SETTLE when `seg_s` changes.
  - In SETTLE, on acceptance:
    - legal digit: go to LOCKED; `BCD` ← digit; `valid` = 1 for one cycle; `blank` = 0; `err` = 0.
    - blank pattern: go to BLANK; `blank` = 1; `err` = 0; `BCD` holds.
    - illegal pattern: go to BAD; `err` = 1; `blank` = 0; `BCD` holds.
  - LOCKED, BLANK and BAD hold while `seg_s` is unchanged.
- **Output hold:**
  - `blank` and `err` hold their values through SETTLE until the next acceptance.
  - `BCD` changes only at acceptance of a legal digit.
- **Reaccepting the same digit:** the same legal digit re-accepted after a glitch produces a fresh `valid` pulse.

## Timing
- **Reset values:**
  - `BCD` = 000, `valid` = 0, `blank` = 1, `err` = 0.
  - Synchroniser flops = 1111111, `cnt` = 0, state BLANK.
- **Reset assertion mid-SETTLE:** aborts the pending acceptance immediately, asynchronously.
- **After reset release:** the first change of `seg_s` away from 1111111 starts a new SETTLE.
- **Latency:** input changes and is first captured at edge k.
  - `seg_s` is updated at edge k+1.
  - `valid` (or the `blank`/`err` update) is registered at edge k+1+`STABLE_CYCLES` and is high for exactly that one cycle.
  - With the default of 4: input captured at edge 0 gives `valid` high after edge 5.
- **Glitch rejection:** a change shorter than `STABLE_CYCLES` cycles restarts the count. No output changes except the state moving to SETTLE.
- **`STABLE_CYCLES` = 1:** acceptance occurs on the edge after the change is seen at `seg_s`.
- **Outputs are registered;** there are no combinational paths from the `s*` inputs.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run → `BCD` = 000, `valid` = 0, `blank` = 1, `err` = 0, with no dependence on a clock edge. Release → outputs unchanged while the inputs stay 1111111.
- **All legal digits:** drive each legal pattern 0..7 for 10 cycles each.
  - `BCD` = 0..7 in order.
  - Exactly 8 `valid` pulses, each 1 cycle wide, at change+5 edges (default parameter).
- **Glitch rejection:** digit 3 is stable; drive digit 6 for 3 cycles, then return to 3.
  - No `valid` during the excursion.
  - After the return, one `valid` with `BCD` = 3 at return+5.
- **Illegal pattern:** drive 0000000 for 10 cycles → `err` = 1 from edge change+5, `BCD` holds its prior value, no `valid`. Then drive digit 2 → `err` = 0 and `valid` pulse, `BCD` = 2.
- **Blank:** from digit 5, drive 1111111 → `blank` = 1 at change+5, no `valid`, `BCD` stays 5.
- **Parameter sweep:** with `STABLE_CYCLES` = 1, drive digit 7 → `valid` at change+2, `BCD` = 7.
